// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } fetch_state_e;

  localparam int unsigned FETCH_PC_STEP = 4;
  localparam logic [31:0] FETCH_NOP     = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Free-running fetch/stall event counters, wrapping modulo 2^32.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_stall,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + 32'(inc_fetched);
    stall_d   = stall_q + 32'(inc_stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, redirect/halt handling.
// Performance counters are compiled in only when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned PC_STEP    = FETCH_PC_STEP,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  localparam logic [31:0] STEP32  = 32'(PC_STEP);
  localparam logic [31:0] LAST_PC = 32'(IMEM_DEPTH - PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         fault_q, fault_d;
  logic         capture;
  logic         redirect_bad;
  logic [31:0]  pc_inc;
  logic [31:0]  pc_seq;

  always_comb begin
    pc_inc = pc_q + STEP32;
    pc_seq = (pc_inc > LAST_PC) ? RESET_PC : pc_inc;
    redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);
  end

  // Priority outside HALT: halt > redirect > capture/hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    fault_d    = fault_q;
    capture    = 1'b0;

    case (state_q)
      ST_HALT: begin
        if (id_valid_q && id_ready) begin
          id_valid_d = 1'b0;
        end
      end
      default: begin
        if (halt) begin
          state_d = ST_HALT;
          if (id_ready) begin
            id_valid_d = 1'b0;
          end
        end else if (redirect_valid) begin
          id_valid_d = 1'b0;
          if (redirect_bad) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end
        end else if (state_q == ST_BOOT) begin
          state_d = ST_FETCH;
        end else if (!id_valid_q || id_ready) begin
          capture = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
    endcase

    if (capture) begin
      id_instr_d = imem_instr;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= FETCH_NOP;
      id_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign fault     = fault_q;

`ifdef FETCH_PERF_EN
  logic stall_evt;
  assign stall_evt = (state_d == ST_HOLD);

  fetch_perf_ctr u_perf (
    .clk          (clk),
    .reset        (reset),
    .inc_fetched  (capture),
    .inc_stall    (stall_evt),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: accepted IF/ID words are scoreboarded.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  assign imem_instr = instr_of(imem_addr);

  fetch_stage #(
    .RESET_PC   (32'd0),
    .PC_STEP    (4),
    .IMEM_DEPTH (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fault          (fault),
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
  );

  // Inputs change 1 time unit after posedge, so at negedge they match the next edge.
  always @(negedge clk) begin
    if (!reset && id_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: accepted id_pc=%h, no entry expected", id_pc);
      end else begin
        sb_exp = exp_q.pop_front();
        if (id_pc !== sb_exp || id_instr !== instr_of(sb_exp)) begin
          errors++;
          $display("FAIL sb_accept: id_pc=%h id_instr=%h, expected pc=%h instr=%h",
                   id_pc, id_instr, sb_exp, instr_of(sb_exp));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    id_ready       = 1'b0;
    cyc();
    cyc();
    exp_q.delete();
  endtask

  task automatic test_queue_empty(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries left, expected 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_idreg: valid=%b instr=%h pc=%h, expected 0/0/0", id_valid, id_instr, id_pc);
    end
    checks++;
    if (imem_addr !== 32'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_fault: addr=%h fault=%b, expected 0/0", imem_addr, fault);
    end
    checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: fetched=%0d stall=%0d, expected 0/0", perf_fetched, perf_stall);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    reset = 1'b0;
    id_ready = 1'b1;
    cyc();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_boot: id_valid=%b one cycle after reset, expected 0", id_valid);
    end
    cyc();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd0 || imem_addr !== 32'd4) begin
      errors++;
      $display("FAIL seq_first: valid=%b pc=%h addr=%h, expected 1/0/4", id_valid, id_pc, imem_addr);
    end
    cyc();
    cyc();
    cyc();
    id_ready = 1'b0;
    checks++;
    if (id_pc !== 32'd12 || imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL seq_fourth: pc=%h addr=%h, expected 12/16", id_pc, imem_addr);
    end
    test_queue_empty("seq");
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    reset = 1'b0;
    id_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    id_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'd8 || imem_addr !== 32'd12) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h addr=%h, expected 1/8/12", i, id_valid, id_pc, imem_addr);
      end
    end
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    checks++;
    if (id_pc !== 32'd12 || id_instr !== instr_of(32'd12)) begin
      errors++;
      $display("FAIL stall_resume: pc=%h instr=%h, expected 12/%h", id_pc, id_instr, instr_of(32'd12));
    end
    checks++;
    if (perf_stall !== (PERF ? 32'd3 : 32'd0) || perf_fetched !== (PERF ? 32'd4 : 32'd0)) begin
      errors++;
      $display("FAIL stall_perf: stall=%0d fetched=%0d, expected %0d/%0d",
               perf_stall, perf_fetched, PERF ? 3 : 0, PERF ? 4 : 0);
    end
    test_queue_empty("stall");
  endtask

  task automatic test_redirect();
    do_reset();
    exp_q.push_back(32'd0);
    reset = 1'b0;
    id_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'd44;
    id_ready = 1'b0;
    cyc();
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'd44) begin
      errors++;
      $display("FAIL redir_flush: valid=%b addr=%h, expected 0/44", id_valid, imem_addr);
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    exp_q.push_back(32'd44);
    cyc();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd44 || fault !== 1'b0) begin
      errors++;
      $display("FAIL redir_target: valid=%b pc=%h fault=%b, expected 1/44/0", id_valid, id_pc, fault);
    end
    cyc();
    id_ready = 1'b0;
    test_queue_empty("redir");
  endtask

  task automatic test_wrap();
    do_reset();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd56;
    id_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    exp_q.push_back(32'd56);
    exp_q.push_back(32'd60);
    exp_q.push_back(32'd0);
    checks++;
    if (imem_addr !== 32'd56 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_boot_redir: addr=%h valid=%b, expected 56/0", imem_addr, id_valid);
    end
    cyc();
    cyc();
    checks++;
    if (imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL wrap_pc: addr=%h after fetching 60, expected 0", imem_addr);
    end
    cyc();
    cyc();
    id_ready = 1'b0;
    checks++;
    if (id_pc !== 32'd4) begin
      errors++;
      $display("FAIL wrap_after: pc=%h, expected 4", id_pc);
    end
    test_queue_empty("wrap");
  endtask

  task automatic test_fault();
    logic [31:0] bad [4];
    bad = '{32'd46, 32'd64, 32'd62, 32'hFFFF_FFFC};
    for (int unsigned i = 0; i < 4; i++) begin
      do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = bad[i];
      cyc();
      checks++;
      if (fault !== 1'b1 || imem_addr !== 32'd4 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_set[%h]: fault=%b addr=%h valid=%b, expected 1/4/0",
                 bad[i], fault, imem_addr, id_valid);
      end
      redirect_pc = 32'd8;
      id_ready = 1'b1;
      cyc();
      cyc();
      checks++;
      if (fault !== 1'b1 || imem_addr !== 32'd4 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL fault_sticky[%h]: fault=%b addr=%h valid=%b, expected 1/4/0",
                 bad[i], fault, imem_addr, id_valid);
      end
      redirect_valid = 1'b0;
    end
    do_reset();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd60;
    cyc();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'd60) begin
      errors++;
      $display("FAIL fault_edge_legal: fault=%b addr=%h, expected 0/60", fault, imem_addr);
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'd46;
    cyc();
    reset = 1'b1;
    halt = 1'b1;
    redirect_pc = 32'd44;
    cyc();
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== 32'd0) begin
      errors++;
      $display("FAIL rst_override: fault=%b addr=%h valid=%b pc=%h instr=%h, expected all 0",
               fault, imem_addr, id_valid, id_pc, id_instr);
    end
    reset = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd0 || imem_addr !== 32'd4) begin
      errors++;
      $display("FAIL rst_restart: valid=%b pc=%h addr=%h, expected 1/0/4", id_valid, id_pc, imem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    reset = 1'b0;
    id_ready = 1'b1;
    cyc();
    cyc();
    halt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd44;
    id_ready = 1'b0;
    cyc();
    checks++;
    if (imem_addr !== 32'd4 || id_valid !== 1'b1 || id_pc !== 32'd0) begin
      errors++;
      $display("FAIL halt_enter: addr=%h valid=%b pc=%h, expected 4/1/0", imem_addr, id_valid, id_pc);
    end
    halt = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    checks++;
    if (id_valid !== 1'b1 || imem_addr !== 32'd4) begin
      errors++;
      $display("FAIL halt_pending: valid=%b addr=%h, expected 1/4", id_valid, imem_addr);
    end
    id_ready = 1'b1;
    exp_q.push_back(32'd0);
    cyc();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_drain: valid=%b after accept, expected 0", id_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd8;
    cyc();
    cyc();
    checks++;
    if (id_valid !== 1'b0 || imem_addr !== 32'd4 || fault !== 1'b0) begin
      errors++;
      $display("FAIL halt_locked: valid=%b addr=%h fault=%b, expected 0/4/0", id_valid, imem_addr, fault);
    end
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    test_queue_empty("halt");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_fault();
    test_reset_override();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
